picorv32_unified_mem_arbiter: RTL and testbench
===============================================

// Module: picorv32_unified_mem_arbiter
// PURPOSE
//  Shares one single-port SRAM between the picorv32 instruction and data ports of the tiny SoC.
//  Each cycle it grants at most one requester, in round-robin order.
//  It routes the SRAM read data back to the owner on the following cycle.
//  It rejects out-of-range addresses with an error response and counts conflict cycles.
// PARAMETERS
//  BaseAddr   32'h8000_0000  byte address mapped to SRAM word 0
//  DepthWords 1<<20          SRAM depth in 32-bit words (power of two)
//  CntWidth   32             width of the saturating conflict counter
// PORTS
//  clk_i        in   1   clock
//  rst_ni       in   1   asynchronous active-low reset
//  i_req_i      in   1   instr request
//  i_gnt_o      out  1   instr request accepted this cycle
//  i_addr_i     in   32  instr byte address
//  i_we_i       in   1   instr write enable
//  i_wdata_i    in   32  instr write data
//  i_strb_i     in   4   instr byte strobes
//  i_rvalid_o   out  1   instr response valid
//  i_rdata_o    out  32  instr response data
//  i_err_o      out  1   instr response is an error (qualified by i_rvalid_o)
//  d_*          same set as i_*, for the data requester
//  sram_req_o   out  1   SRAM access
//  sram_we_o    out  1   SRAM write
//  sram_addr_o  out  32  SRAM word index = (addr-BaseAddr)>>2
//  sram_wdata_o out  32  SRAM write data
//  sram_strb_o  out  4   SRAM byte strobes
//  sram_rdata_i in   32  SRAM read data, valid one cycle after sram_req_o
//  conflict_cnt_o out CntWidth  cycles in which both requesters requested
// BEHAVIOUR
//  Reset
//   - All outputs are 0. Round-robin pointer last_o = DATA, so INSTR wins the first conflict.
//   - Response pipeline is empty. Asserting reset mid-access drops the pending response: no rvalid after reset.
//  Arbitration (combinational, same cycle)
//   - Only one requesting: it is granted.
//   - Both requesting: grant the side that is not last_o; assert exactly one gnt.
//   - last_o updates on every grant.
//   - No lock: a requester holding req across cycles competes afresh each cycle.
//  Range check
//   - In range: BaseAddr <= addr < BaseAddr + 4*DepthWords, computed with 33-bit arithmetic so there is no wrap.
//   - In-range grant: sram_req_o=1 and the request fields are forwarded to the SRAM the same cycle.
//   - Out-of-range grant: still gnt=1, but sram_req_o=0. Flagged err for the response.
//  Response (one-cycle latency, fully pipelined)
//   - Registers {valid, owner, err, we} on each grant.
//   - Next cycle the owner sees rvalid=1.
//   - rdata = sram_rdata_i for an in-range read. rdata = 0 for writes and for errors.
//   - err = 1 only for out-of-range accesses.
//   - The other side sees rvalid=0 and rdata=0.
//   - Back-to-back grants produce back-to-back rvalids in grant order.
//  Counter
//   - conflict_cnt_o increments on each cycle with i_req_i && d_req_i.
//   - Saturates at all-ones; no wrap.
//  Unaligned addresses
//   - addr[1:0] is ignored; strobes select the bytes.
//  Invariants
//   - i_gnt_o & d_gnt_o == 0.
//   - sram_req_o implies exactly one gnt.
//   - rvalid is never asserted without a grant in the previous cycle.
// TESTING
//  1. Instr-only read at 0x8000_0010, SRAM word 4 = 0xDEADBEEF
//     -> i_gnt same cycle, sram_addr=4; next cycle i_rvalid=1, i_rdata=0xDEADBEEF, d_rvalid=0.
//  2. Both request for 4 cycles right after reset
//     -> grants I,D,I,D; rvalids alternate I,D,I,D one cycle later; conflict_cnt=4.
//  3. Data write addr 0x8000_0004, wdata 0x11223344, strb 4'b0011
//     -> sram_we=1, sram_strb=0011; next cycle d_rvalid=1, d_rdata=0, d_err=0.
//  4. Data read at 0x7FFF_FFFC and at BaseAddr+4*DepthWords
//     -> d_gnt=1, sram_req=0; next cycle d_rvalid=1, d_err=1, d_rdata=0.
//  5. rst_ni low in the cycle after a grant
//     -> all outputs 0 immediately, no rvalid after release; next conflict granted to INSTR.
//  6. Counter preset near saturation (CntWidth=4), 20 conflict cycles -> conflict_cnt_o stays 4'hF.

Source files
------------

// File: rtl/picorv32_unified_mem_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between the picorv32 instruction and
// data ports, with address range checking, one-cycle response routing and a conflict counter.
module picorv32_unified_mem_arbiter #(
  parameter logic [31:0] BaseAddr   = 32'h8000_0000,
  parameter int unsigned DepthWords = 32'd1 << 20,
  parameter int unsigned CntWidth   = 32'd32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                i_req_i,
  output logic                i_gnt_o,
  input  logic [31:0]         i_addr_i,
  input  logic                i_we_i,
  input  logic [31:0]         i_wdata_i,
  input  logic [3:0]          i_strb_i,
  output logic                i_rvalid_o,
  output logic [31:0]         i_rdata_o,
  output logic                i_err_o,
  input  logic                d_req_i,
  output logic                d_gnt_o,
  input  logic [31:0]         d_addr_i,
  input  logic                d_we_i,
  input  logic [31:0]         d_wdata_i,
  input  logic [3:0]          d_strb_i,
  output logic                d_rvalid_o,
  output logic [31:0]         d_rdata_o,
  output logic                d_err_o,
  output logic                sram_req_o,
  output logic                sram_we_o,
  output logic [31:0]         sram_addr_o,
  output logic [31:0]         sram_wdata_o,
  output logic [3:0]          sram_strb_o,
  input  logic [31:0]         sram_rdata_i,
  output logic [CntWidth-1:0] conflict_cnt_o
);

  localparam logic OwnerI = 1'b0;
  localparam logic OwnerD = 1'b1;

  // Bounds held in 33 bits so the upper limit cannot wrap past 2^32.
  localparam logic [32:0] AddrLo = {1'b0, BaseAddr};
  localparam logic [32:0] AddrHi = AddrLo + (33'(DepthWords) << 2);

  function automatic logic addr_in_range(input logic [31:0] addr);
    logic [32:0] wide_addr;
    wide_addr = {1'b0, addr};
    return (wide_addr >= AddrLo) && (wide_addr < AddrHi);
  endfunction

  logic                last_r;
  logic                rsp_valid_r;
  logic                rsp_owner_r;
  logic                rsp_err_r;
  logic                rsp_we_r;
  logic [CntWidth-1:0] cnt_r;

  logic        i_gnt_s;
  logic        d_gnt_s;
  logic        gnt_any_s;
  logic        sel_owner_s;
  logic [31:0] sel_addr_s;
  logic        sel_we_s;
  logic [31:0] sel_wdata_s;
  logic [3:0]  sel_strb_s;
  logic        sel_in_range_s;
  logic [31:0] word_idx_s;
  logic [31:0] rsp_data_s;

  // Grant selection: a lone requester wins, on conflict the side not served last wins.
  always_comb begin
    i_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    if (i_req_i && d_req_i) begin
      if (last_r == OwnerD) begin
        i_gnt_s = 1'b1;
      end else begin
        d_gnt_s = 1'b1;
      end
    end else if (i_req_i) begin
      i_gnt_s = 1'b1;
    end else if (d_req_i) begin
      d_gnt_s = 1'b1;
    end else begin
      i_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end
  end

  // Request field mux for the granted side.
  always_comb begin
    gnt_any_s   = i_gnt_s | d_gnt_s;
    sel_owner_s = OwnerI;
    sel_addr_s  = i_addr_i;
    sel_we_s    = i_we_i;
    sel_wdata_s = i_wdata_i;
    sel_strb_s  = i_strb_i;
    if (d_gnt_s) begin
      sel_owner_s = OwnerD;
      sel_addr_s  = d_addr_i;
      sel_we_s    = d_we_i;
      sel_wdata_s = d_wdata_i;
      sel_strb_s  = d_strb_i;
    end else begin
      sel_owner_s = OwnerI;
    end
    sel_in_range_s = addr_in_range(sel_addr_s);
    word_idx_s     = (sel_addr_s - BaseAddr) >> 2;
  end

  // SRAM port drive; everything is held at zero unless an in-range access is granted.
  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = 32'd0;
    sram_wdata_o = 32'd0;
    sram_strb_o  = 4'd0;
    if (gnt_any_s && sel_in_range_s) begin
      sram_req_o   = 1'b1;
      sram_we_o    = sel_we_s;
      sram_addr_o  = word_idx_s;
      sram_wdata_o = sel_wdata_s;
      sram_strb_o  = sel_strb_s;
    end else begin
      sram_req_o   = 1'b0;
    end
  end

  // Round-robin pointer, response pipeline stage and saturating conflict counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_r      <= OwnerD;
      rsp_valid_r <= 1'b0;
      rsp_owner_r <= OwnerI;
      rsp_err_r   <= 1'b0;
      rsp_we_r    <= 1'b0;
      cnt_r       <= '0;
    end else begin
      rsp_valid_r <= gnt_any_s;
      if (gnt_any_s) begin
        last_r      <= sel_owner_s;
        rsp_owner_r <= sel_owner_s;
        rsp_err_r   <= ~sel_in_range_s;
        rsp_we_r    <= sel_we_s;
      end else begin
        rsp_err_r   <= 1'b0;
        rsp_we_r    <= 1'b0;
      end
      if (i_req_i && d_req_i && !(&cnt_r)) begin
        cnt_r <= cnt_r + CntWidth'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Route the pending response to its owner; writes and errors return zero data.
  always_comb begin
    rsp_data_s = 32'd0;
    i_rvalid_o = 1'b0;
    d_rvalid_o = 1'b0;
    i_rdata_o  = 32'd0;
    d_rdata_o  = 32'd0;
    i_err_o    = 1'b0;
    d_err_o    = 1'b0;
    if (rsp_valid_r && !rsp_err_r && !rsp_we_r) begin
      rsp_data_s = sram_rdata_i;
    end else begin
      rsp_data_s = 32'd0;
    end
    if (rsp_valid_r) begin
      case (rsp_owner_r)
        OwnerI: begin
          i_rvalid_o = 1'b1;
          i_rdata_o  = rsp_data_s;
          i_err_o    = rsp_err_r;
        end
        OwnerD: begin
          d_rvalid_o = 1'b1;
          d_rdata_o  = rsp_data_s;
          d_err_o    = rsp_err_r;
        end
        default: begin
          i_rvalid_o = 1'b0;
          d_rvalid_o = 1'b0;
        end
      endcase
    end else begin
      i_rvalid_o = 1'b0;
    end
  end

  assign i_gnt_o        = i_gnt_s;
  assign d_gnt_o        = d_gnt_s;
  assign conflict_cnt_o = cnt_r;

endmodule

// File: tb/tb_picorv32_unified_mem_arbiter.sv
// Directed self-checking bench for picorv32_unified_mem_arbiter with a small SRAM model
// and a second instance using a 4-bit conflict counter to exercise saturation.
module tb_picorv32_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        i_req, i_we, d_req, d_we;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic [3:0]  i_strb, d_strb;
  logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        sram_req, sram_we;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic [3:0]  sram_strb;
  logic [31:0] cnt;

  logic        i_gnt4, i_rvalid4, i_err4, d_gnt4, d_rvalid4, d_err4;
  logic [31:0] i_rdata4, d_rdata4;
  logic        sram_req4, sram_we4;
  logic [31:0] sram_addr4, sram_wdata4;
  logic [3:0]  sram_strb4;
  logic [3:0]  cnt4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  picorv32_unified_mem_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .i_req_i(i_req), .i_gnt_o(i_gnt), .i_addr_i(i_addr), .i_we_i(i_we),
    .i_wdata_i(i_wdata), .i_strb_i(i_strb), .i_rvalid_o(i_rvalid),
    .i_rdata_o(i_rdata), .i_err_o(i_err),
    .d_req_i(d_req), .d_gnt_o(d_gnt), .d_addr_i(d_addr), .d_we_i(d_we),
    .d_wdata_i(d_wdata), .d_strb_i(d_strb), .d_rvalid_o(d_rvalid),
    .d_rdata_o(d_rdata), .d_err_o(d_err),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_strb_o(sram_strb), .sram_rdata_i(sram_rdata),
    .conflict_cnt_o(cnt)
  );

  picorv32_unified_mem_arbiter #(.CntWidth(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_ni),
    .i_req_i(i_req), .i_gnt_o(i_gnt4), .i_addr_i(i_addr), .i_we_i(i_we),
    .i_wdata_i(i_wdata), .i_strb_i(i_strb), .i_rvalid_o(i_rvalid4),
    .i_rdata_o(i_rdata4), .i_err_o(i_err4),
    .d_req_i(d_req), .d_gnt_o(d_gnt4), .d_addr_i(d_addr), .d_we_i(d_we),
    .d_wdata_i(d_wdata), .d_strb_i(d_strb), .d_rvalid_o(d_rvalid4),
    .d_rdata_o(d_rdata4), .d_err_o(d_err4),
    .sram_req_o(sram_req4), .sram_we_o(sram_we4), .sram_addr_o(sram_addr4),
    .sram_wdata_o(sram_wdata4), .sram_strb_o(sram_strb4), .sram_rdata_i(sram_rdata),
    .conflict_cnt_o(cnt4)
  );

  // SRAM model: words 4 and 8 are fixed patterns, other words come from writes.
  logic [31:0] mem [0:255];
  logic [7:0]  rd_idx_r;
  always @(posedge clk) begin
    if (sram_req && sram_we) begin
      for (int b = 0; b < 4; b++)
        if (sram_strb[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end else if (sram_req) begin
      rd_idx_r <= sram_addr[7:0];
    end
  end
  assign sram_rdata = (rd_idx_r == 8'd4) ? 32'hDEAD_BEEF :
                      (rd_idx_r == 8'd8) ? 32'hCAFE_F00D : mem[rd_idx_r];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    i_req = 1'b0; i_we = 1'b0; i_addr = 32'd0; i_wdata = 32'd0; i_strb = 4'hF;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_strb = 4'hF;
  endtask

  initial begin
    rst_ni = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_i_gnt", {31'd0, i_gnt}, 32'd0);
    check("rst_sram_req", {31'd0, sram_req}, 32'd0);
    check("rst_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    check("rst_cnt", cnt, 32'd0);

    // Conflict right after reset: I, D, I, D with responses one cycle later.
    @(negedge clk); rst_ni = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      i_req = 1'b1; i_addr = 32'h8000_0010;
      d_req = 1'b1; d_addr = 32'h8000_0020;
      #1;
      check("rr_i_gnt", {31'd0, i_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_d_gnt", {31'd0, d_gnt}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k > 0) begin
        check("rr_i_rvalid", {31'd0, i_rvalid}, (k % 2 == 1) ? 32'd1 : 32'd0);
        check("rr_d_rvalid", {31'd0, d_rvalid}, (k % 2 == 0) ? 32'd1 : 32'd0);
        if (k % 2 == 1) check("rr_i_rdata", i_rdata, 32'hDEAD_BEEF);
        else            check("rr_d_rdata", d_rdata, 32'hCAFE_F00D);
      end
    end
    @(negedge clk); idle(); #1;
    check("rr_last_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    check("rr_last_d_rdata", d_rdata, 32'hCAFE_F00D);
    check("rr_cnt", cnt, 32'd4);

    // Instruction-only read of word 4.
    @(negedge clk); i_req = 1'b1; i_addr = 32'h8000_0010; #1;
    check("i_rd_gnt", {30'd0, i_gnt, d_gnt}, 32'd2);
    check("i_rd_sram_req", {31'd0, sram_req}, 32'd1);
    check("i_rd_sram_addr", sram_addr, 32'd4);
    @(negedge clk); idle(); #1;
    check("i_rd_rvalid", {31'd0, i_rvalid}, 32'd1);
    check("i_rd_rdata", i_rdata, 32'hDEAD_BEEF);
    check("i_rd_err", {31'd0, i_err}, 32'd0);
    check("i_rd_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    check("i_rd_d_rdata", d_rdata, 32'd0);

    // Data write with partial strobes, then unaligned read-back of the same word.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8000_0004; d_wdata = 32'h1122_3344; d_strb = 4'b0011;
    #1;
    check("d_wr_gnt", {30'd0, i_gnt, d_gnt}, 32'd1);
    check("d_wr_sram_we", {30'd0, sram_req, sram_we}, 32'd3);
    check("d_wr_sram_strb", {28'd0, sram_strb}, 32'd3);
    check("d_wr_sram_addr", sram_addr, 32'd1);
    check("d_wr_sram_wdata", sram_wdata, 32'h1122_3344);
    @(negedge clk);
    d_we = 1'b0; d_addr = 32'h8000_0005; d_strb = 4'hF; #1;
    check("d_wr_rvalid", {31'd0, d_rvalid}, 32'd1);
    check("d_wr_rdata", d_rdata, 32'd0);
    check("d_wr_err", {31'd0, d_err}, 32'd0);
    check("d_unal_sram_addr", sram_addr, 32'd1);
    @(negedge clk); idle(); #1;
    check("d_unal_rdata_lo", d_rdata & 32'h0000_FFFF, 32'h0000_3344);

    // Range boundaries: below base, one past the top, last valid word.
    @(negedge clk); d_req = 1'b1; d_addr = 32'h7FFF_FFFC; #1;
    check("oor_lo_gnt", {31'd0, d_gnt}, 32'd1);
    check("oor_lo_sram_req", {31'd0, sram_req}, 32'd0);
    @(negedge clk); d_addr = 32'h8040_0000; #1;
    check("oor_hi_gnt", {31'd0, d_gnt}, 32'd1);
    check("oor_hi_sram_req", {31'd0, sram_req}, 32'd0);
    check("oor_lo_rsp", {d_rvalid, d_err, 30'd0}, 32'hC000_0000);
    check("oor_lo_rdata", d_rdata, 32'd0);
    @(negedge clk); d_addr = 32'h803F_FFFC; #1;
    check("top_sram_req", {31'd0, sram_req}, 32'd1);
    check("top_sram_addr", sram_addr, 32'h000F_FFFF);
    check("oor_hi_rsp", {d_rvalid, d_err, 30'd0}, 32'hC000_0000);
    check("oor_hi_rdata", d_rdata, 32'd0);
    @(negedge clk); idle(); #1;
    check("top_rsp", {d_rvalid, d_err, 30'd0}, 32'h8000_0000);

    // Reset in the cycle after a grant drops the response and restores the pointer.
    @(negedge clk); i_req = 1'b1; i_addr = 32'h8000_0010;
    @(negedge clk); idle(); rst_ni = 1'b0; #1;
    check("rst_mid_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    check("rst_mid_i_rdata", i_rdata, 32'd0);
    check("rst_mid_cnt", cnt, 32'd0);
    @(negedge clk); rst_ni = 1'b1;
    i_req = 1'b1; i_addr = 32'h8000_0010; d_req = 1'b1; d_addr = 32'h8000_0020; #1;
    check("rst_post_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    check("rst_post_gnt", {30'd0, i_gnt, d_gnt}, 32'd2);

    // Saturation: 20 conflict cycles from reset.
    @(negedge clk); idle(); rst_ni = 1'b0;
    @(negedge clk); rst_ni = 1'b1;
    i_req = 1'b1; i_addr = 32'h8000_0010; d_req = 1'b1; d_addr = 32'h8000_0020;
    for (int k = 0; k < 20; k++) begin
      #1;
      check("sat_one_gnt", {31'd0, i_gnt ^ d_gnt}, 32'd1);
      @(negedge clk);
    end
    idle(); #1;
    check("sat_cnt4", {28'd0, cnt4}, 32'h0000_000F);
    check("sat_cnt32", cnt, 32'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
